uart_rx_core: RTL and testbench

- Synthesizable UART receiver. Consumes the serial `rx` line that the bench UART interface drives via `send_rx`.
- Recovers framed characters: start bit, 5–8 data bits LSB-first, optional even/odd parity, 1 or 2 stop bits.
- Presents each character on a valid/ready byte port with error sideband. Sits between the pad and the APB UART's RX FIFO.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx_core.sv | 158 +++++++++++++++
 tb/tb_uart_rx_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, COMMIT} uart_rx_state_e;
    typedef enum logic [1:0] {BITS5, BITS6, BITS7, BITS8} uart_data_bits_e;
    localparam int UART_MIN_CLK_DIV    = 4;
    localparam int UART_MIN_CLK_DIV_MV = 6;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: rx metastability synchronizer with falling-edge detect
//   clk_i, arst_ni : clock, async active-low reset (flops reset to idle-high)
//   rx_i           : raw asynchronous serial input
//   rx_s           : synchronized rx level
//   fall_o         : rx_s went 1 -> 0 this cycle
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic rx_i,
    output logic rx_s,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '1;
            prev   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev   <= rx_s;
        end
    end
    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign fall_o = prev & ~rx_s;
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver, 5-8 data bits, optional parity, 1/2 stop bits
//   clk_i, arst_ni    : clock, async active-low reset
//   en_i              : receiver enable (low drops any frame in flight)
//   rx_i              : serial input, idle high
//   cfg_*             : divisor, data bits, parity enable/type, two stop bits
//   data_o, valid_o, ready_i, parity_err_o, frame_err_o : character port
//   overrun_o         : pulse when a completed character is dropped
//   busy_o            : receiver not idle
// Optional: define UART_RX_MAJORITY_VOTE_EN for 2-of-3 sampling around each tick.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV_W   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 en_i,
    input  logic                 rx_i,
    input  logic [CLK_DIV_W-1:0] cfg_clk_div_i,
    input  logic [1:0]           cfg_data_bits_i,
    input  logic                 cfg_parity_en_i,
    input  logic                 cfg_parity_type_i,
    input  logic                 cfg_stop2_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int MIN_DIV = UART_MIN_CLK_DIV_MV;
`else
    localparam int MIN_DIV = UART_MIN_CLK_DIV;
`endif
    localparam logic [CLK_DIV_W-1:0] MIN_DIV_V = CLK_DIV_W'(MIN_DIV);
    uart_rx_state_e        state, state_n;
    uart_data_bits_e       bits;
    logic                  rx_s, fall, sampling, tick, act, smp;
    logic                  par_en, par_odd, stop2, par_acc, perr, ferr;
    logic [CLK_DIV_W-1:0]  div_in, div, cnt, reload;
    logic [2:0]            idx, last;
    logic [7:0]            shreg;
    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .rx_i   (rx_i),
        .rx_s   (rx_s),
        .fall_o (fall)
    );
    assign div_in   = (cfg_clk_div_i < MIN_DIV_V) ? MIN_DIV_V : cfg_clk_div_i;
    assign sampling = (state != IDLE) && (state != COMMIT);
    assign last     = 3'(bits) + 3'd4;
    assign busy_o   = state != IDLE;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rx_d1, rx_d2, tick_q;
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_d1  <= 1'b1;
            rx_d2  <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            rx_d1  <= rx_s;
            rx_d2  <= rx_d1;
            tick_q <= tick && en_i;
        end
    end
    // Acting one cycle after the tick costs a cycle, so reload one less to keep the bit period.
    assign tick   = sampling && (cnt == '0) && !tick_q;
    assign act    = tick_q;
    assign smp    = maj3(rx_d2, rx_d1, rx_s);
    assign reload = div - CLK_DIV_W'(2);
`else
    assign tick   = sampling && (cnt == '0);
    assign act    = tick;
    assign smp    = rx_s;
    assign reload = div - CLK_DIV_W'(1);
`endif
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) state <= IDLE;
        else          state <= state_n;
    end
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (fall && en_i) state_n = START;
            START:   if (act) state_n = smp ? IDLE : DATA;
            DATA:    if (act && idx == last) state_n = par_en ? PARITY : STOP1;
            PARITY:  if (act) state_n = STOP1;
            STOP1:   if (act) state_n = stop2 ? STOP2 : COMMIT;
            STOP2:   if (act) state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (!en_i) state_n = IDLE;
    end
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt          <= '0;
            div          <= '0;
            idx          <= '0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            bits         <= BITS8;
            par_en       <= 1'b0;
            par_odd      <= 1'b0;
            stop2        <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (state == IDLE && state_n == START) begin
                cnt     <= div_in >> 1;
                div     <= div_in;
                bits    <= uart_data_bits_e'(cfg_data_bits_i);
                par_en  <= cfg_parity_en_i;
                par_odd <= cfg_parity_type_i;
                stop2   <= cfg_stop2_i;
                idx     <= '0;
                shreg   <= '0;
                par_acc <= 1'b0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
            end else if (act) begin
                cnt <= reload;
                unique case (state)
                    DATA: begin
                        shreg[idx] <= smp;
                        par_acc    <= par_acc ^ smp;
                        idx        <= idx + 1'b1;
                    end
                    PARITY:  perr <= smp ^ par_acc ^ par_odd;
                    STOP1:   ferr <= !smp;
                    STOP2:   ferr <= ferr | !smp;
                    default: ;
                endcase
            end
            if (state == COMMIT && valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else if (state == COMMIT) begin
                data_o       <= shreg;
                parity_err_o <= perr;
                frame_err_o  <= ferr;
                valid_o      <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames checked against a character-level scoreboard
module tb_uart_rx_core;
    localparam int DIV = 16;
    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } chr_t;
    logic        clk = 1'b0;
    logic        arst_ni = 1'b1;
    logic        en_i = 1'b0;
    logic        rx_i = 1'b1;
    logic        ready_i = 1'b1;
    logic [15:0] cfg_clk_div_i = 16'(DIV);
    logic [1:0]  cfg_data_bits_i = 2'd3;
    logic        cfg_parity_en_i = 1'b0;
    logic        cfg_parity_type_i = 1'b0;
    logic        cfg_stop2_i = 1'b0;
    logic [7:0]  data_o;
    logic        valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;
    chr_t        exp_q[$];
    int          n_checks = 0, n_fail = 0, ov_seen = 0, exp_ov = 0;
    logic [7:0]  last_d = '0;
    logic        last_pe = 1'b0, last_fe = 1'b0;
    always #5 clk = ~clk;
    uart_rx_core #(.CLK_DIV_W(16), .SYNC_STAGES(2)) dut (
        .clk_i            (clk),
        .arst_ni          (arst_ni),
        .en_i             (en_i),
        .rx_i             (rx_i),
        .cfg_clk_div_i    (cfg_clk_div_i),
        .cfg_data_bits_i  (cfg_data_bits_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_type_i(cfg_parity_type_i),
        .cfg_stop2_i      (cfg_stop2_i),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .parity_err_o     (parity_err_o),
        .frame_err_o      (frame_err_o),
        .overrun_o        (overrun_o),
        .busy_o           (busy_o)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Every cycle a character is presented it must match the oldest expected one.
    always @(negedge clk) begin
        if (overrun_o) ov_seen++;
        if (arst_ni && valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                check("data", 32'(data_o), 32'(exp_q[0].d));
                check("parity_err", 32'(parity_err_o), 32'(exp_q[0].pe));
                check("frame_err", 32'(frame_err_o), 32'(exp_q[0].fe));
                if (ready_i) begin
                    last_d  = data_o;
                    last_pe = parity_err_o;
                    last_fe = frame_err_o;
                    void'(exp_q.pop_front());
                end
            end
        end
    end
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic drive_bit(input logic b);
        rx_i = b;
        cycles(DIV);
    endtask
    task automatic model_push(input chr_t c);
        if (exp_q.size() > 0 && !ready_i) exp_ov++;
        else exp_q.push_back(c);
    endtask
    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen, input logic podd,
                              input logic st2, input logic bad_par, input logic s1, input logic s2);
        logic [7:0] dm;
        logic       p;
        chr_t       c;
        dm = d & 8'((1 << nb) - 1);
        p  = (^dm) ^ podd ^ bad_par;
        cfg_data_bits_i   = 2'(nb - 5);
        cfg_parity_en_i   = pen;
        cfg_parity_type_i = podd;
        cfg_stop2_i       = st2;
        c.d  = dm;
        c.pe = pen && (((^dm) ^ p) != podd);
        c.fe = !s1 || (st2 && !s2);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(dm[i]);
        if (pen) drive_bit(p);
        if (st2) begin
            drive_bit(s1);
            model_push(c);
            drive_bit(s2);
        end else begin
            model_push(c);
            drive_bit(s1);
        end
    endtask
    task automatic wait_empty(input string name);
        for (int i = 0; i < 8 * DIV; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check(name, 32'(exp_q.size()), 32'd0);
        cycles(2);
    endtask
    initial begin
        #1 arst_ni = 1'b0;
        #2;
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_flags", {29'd0, parity_err_o, frame_err_o, overrun_o}, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        cycles(3);
        arst_ni = 1'b1;
        en_i    = 1'b1;
        cycles(2 * DIV);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_empty("drain_a5");
        check("lit_a5", {last_d, 7'd0, last_pe, 7'd0, last_fe, 8'd0}, 32'hA5000000);
        cycles(DIV);
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_empty("drain_par_ok");
        check("lit_par_ok", {last_d, 7'd0, last_pe, 16'd0}, 32'h55000000);
        cycles(DIV);
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_empty("drain_par_bad");
        check("lit_par_bad", {last_d, 7'd0, last_pe, 16'd0}, 32'h55010000);
        cycles(DIV);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_empty("drain_break");
        check("lit_break", {last_d, 7'd0, last_fe, 16'd0}, 32'h96010000);
        cycles(40 * DIV);
        check("break_idle", 32'(busy_o), 32'd0);
        rx_i = 1'b1;
        cycles(2 * DIV);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_empty("drain_after_break");
        check("lit_after_break", {last_d, 7'd0, last_fe, 16'd0}, 32'h5A000000);
        cycles(DIV);
        ready_i = 1'b0;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycles(DIV);
        check("overrun_count", 32'(ov_seen), 32'd1);
        check("overrun_model", 32'(ov_seen), 32'(exp_ov));
        check("held_data", 32'(data_o), 32'h11);
        check("held_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        wait_empty("drain_overrun");
        check("valid_dropped", 32'(valid_o), 32'd0);
        check("lit_overrun_data", 32'(last_d), 32'h11);
        cycles(DIV);
        rx_i = 1'b0;
        cycles(5);
        check("false_start_busy", 32'(busy_o), 32'd1);
        rx_i = 1'b1;
        cycles(2 * DIV);
        check("false_start_idle", 32'(busy_o), 32'd0);
        check("false_start_valid", 32'(valid_o), 32'd0);
        check("false_start_flags", {30'd0, parity_err_o, frame_err_o}, 32'd0);
        cycles(DIV);
        cfg_data_bits_i = 2'd3;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("mid_frame_busy", 32'(busy_o), 32'd1);
        arst_ni = 1'b0;
        #1;
        check("arst_data", 32'(data_o), 32'h0);
        check("arst_valid_busy", {30'd0, valid_o, busy_o}, 32'd0);
        check("arst_flags", {29'd0, parity_err_o, frame_err_o, overrun_o}, 32'd0);
        exp_q.delete();
        rx_i = 1'b1;
        cycles(3);
        arst_ni = 1'b1;
        cycles(2 * DIV);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_empty("drain_3c");
        check("lit_3c", {last_d, 7'd0, last_pe, 7'd0, last_fe, 8'd0}, 32'h3C000000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
